// File: rtl/dynamic_branch_predictor_if.sv
// IF-lookup / ID-resolve signal bundle between the pipeline and dynamic_branch_predictor.
interface dynamic_branch_predictor_if;
  logic        enable;
  logic [15:0] PC_curr;
  logic        IF_ID_stall;
  logic        ID_is_branch;
  logic        ID_actual_taken;
  logic [15:0] ID_actual_target;
  logic        predicted_taken;
  logic [15:0] predicted_target;
  logic        update_PC;
  logic [15:0] PC_redirect;

  modport master (
    output enable, PC_curr, IF_ID_stall, ID_is_branch, ID_actual_taken, ID_actual_target,
    input  predicted_taken, predicted_target, update_PC, PC_redirect
  );

  modport slave (
    input  enable, PC_curr, IF_ID_stall, ID_is_branch, ID_actual_taken, ID_actual_target,
    output predicted_taken, predicted_target, update_PC, PC_redirect
  );
endinterface

// File: rtl/dynamic_branch_predictor.sv
// BTB + 2-bit counter branch predictor with ID-stage resolve and mispredict redirect.
// Define DYNAMIC_PREDICT_EN to build the tables; otherwise static not-taken prediction.
module dynamic_branch_predictor #(
  parameter int unsigned INDEX_BITS = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  dynamic_branch_predictor_if.slave  bus
);

  logic [15:0] pc_plus2_c;
  logic        resolve_c;

  assign pc_plus2_c = bus.PC_curr + 16'd2;
  assign resolve_c  = bus.ID_is_branch & ~bus.IF_ID_stall;

`ifdef DYNAMIC_PREDICT_EN

  localparam int unsigned ENTRIES = 32'd1 << INDEX_BITS;
  localparam int unsigned TAG_W   = 15 - INDEX_BITS;

  typedef logic [INDEX_BITS-1:0] idx_t;
  typedef logic [TAG_W-1:0]      tag_t;

  logic        valid_q  [ENTRIES];
  logic        valid_d  [ENTRIES];
  tag_t        tag_q    [ENTRIES];
  tag_t        tag_d    [ENTRIES];
  logic [15:0] target_q [ENTRIES];
  logic [15:0] target_d [ENTRIES];
  logic [1:0]  cnt_q    [ENTRIES];
  logic [1:0]  cnt_d    [ENTRIES];

  logic [15:0] if_id_pc_q, if_id_pc_d;
  logic        if_id_pred_taken_q, if_id_pred_taken_d;
  logic [15:0] if_id_pred_target_q, if_id_pred_target_d;

  idx_t        if_idx_c, id_idx_c;
  tag_t        if_tag_c, id_tag_c;
  logic        if_hit_c, id_hit_c;
  logic        pred_taken_c;
  logic        phantom_c;
  logic        mispredict_c;
  logic        update_pc_c;
  logic [15:0] id_pc_plus2_c;
  logic [15:0] actual_next_c;

  // IF lookup from registered tables (no bypass of the same-cycle training write)
  assign if_idx_c     = bus.PC_curr[INDEX_BITS:1];
  assign if_tag_c     = bus.PC_curr[15:INDEX_BITS+1];
  assign if_hit_c     = valid_q[if_idx_c] && (tag_q[if_idx_c] == if_tag_c);
  assign pred_taken_c = ~rst & bus.enable & if_hit_c & cnt_q[if_idx_c][1];

  assign bus.predicted_taken  = pred_taken_c;
  assign bus.predicted_target = pred_taken_c ? target_q[if_idx_c] : pc_plus2_c;

  // ID resolve against the prediction carried in the IF/ID copy
  assign id_idx_c      = if_id_pc_q[INDEX_BITS:1];
  assign id_tag_c      = if_id_pc_q[15:INDEX_BITS+1];
  assign id_hit_c      = valid_q[id_idx_c] && (tag_q[id_idx_c] == id_tag_c);
  assign id_pc_plus2_c = if_id_pc_q + 16'd2;
  assign actual_next_c = bus.ID_actual_taken ? bus.ID_actual_target : id_pc_plus2_c;
  assign phantom_c     = ~bus.ID_is_branch & if_id_pred_taken_q & ~bus.IF_ID_stall;
  assign mispredict_c  = (if_id_pred_taken_q != bus.ID_actual_taken) ||
                         (if_id_pred_taken_q && bus.ID_actual_taken &&
                          (if_id_pred_target_q != bus.ID_actual_target));
  assign update_pc_c   = ~rst & ((resolve_c & mispredict_c) | phantom_c);

  assign bus.update_PC   = update_pc_c;
  assign bus.PC_redirect = rst       ? 16'h0000 :
                           phantom_c ? id_pc_plus2_c : actual_next_c;

  // Table training on resolve; a phantom hit invalidates the aliasing entry
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (resolve_c) begin
      if (id_hit_c) begin
        if (bus.ID_actual_taken) begin
          if (cnt_q[id_idx_c] != 2'b11) cnt_d[id_idx_c] = cnt_q[id_idx_c] + 2'd1;
          target_d[id_idx_c] = bus.ID_actual_target;
        end else if (cnt_q[id_idx_c] != 2'b00) begin
          cnt_d[id_idx_c] = cnt_q[id_idx_c] - 2'd1;
        end
      end else if (bus.ID_actual_taken) begin
        valid_d[id_idx_c]  = 1'b1;
        tag_d[id_idx_c]    = id_tag_c;
        target_d[id_idx_c] = bus.ID_actual_target;
        cnt_d[id_idx_c]    = 2'b10;
      end
    end else if (phantom_c) begin
      valid_d[id_idx_c] = 1'b0;
    end
  end

  // IF/ID prediction copy: flush beats load, stall holds
  always_comb begin
    if_id_pc_d          = if_id_pc_q;
    if_id_pred_taken_d  = if_id_pred_taken_q;
    if_id_pred_target_d = if_id_pred_target_q;
    if (update_pc_c) begin
      if_id_pc_d          = 16'h0000;
      if_id_pred_taken_d  = 1'b0;
      if_id_pred_target_d = 16'h0000;
    end else if (bus.enable && !bus.IF_ID_stall) begin
      if_id_pc_d          = bus.PC_curr;
      if_id_pred_taken_d  = pred_taken_c;
      if_id_pred_target_d = bus.predicted_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 16'h0000;
        cnt_q[i]    <= 2'b01;
      end
      if_id_pc_q          <= 16'h0000;
      if_id_pred_taken_q  <= 1'b0;
      if_id_pred_target_q <= 16'h0000;
    end else begin
      valid_q             <= valid_d;
      tag_q               <= tag_d;
      target_q            <= target_d;
      cnt_q               <= cnt_d;
      if_id_pc_q          <= if_id_pc_d;
      if_id_pred_taken_q  <= if_id_pred_taken_d;
      if_id_pred_target_q <= if_id_pred_target_d;
    end
  end

`else

  // Static not-taken: every taken branch redirects, nothing is stored
  logic unused_static;
  assign unused_static = bus.enable ^ clk;

  assign bus.predicted_taken  = 1'b0;
  assign bus.predicted_target = pc_plus2_c;
  assign bus.update_PC        = ~rst & resolve_c & bus.ID_actual_taken;
  assign bus.PC_redirect      = rst ? 16'h0000 : bus.ID_actual_target;

`endif

endmodule
